// File: rtl/r5_pkg.sv
// r5_pkg: shared radix-5 stage types and defaults
package r5_pkg;
  localparam int RADIX = 5;
  localparam int N_DEF = 25;
  localparam int LAT_DEF = 8;
  localparam int AW_DEF = 5;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic valid;
    logic sof;
    logic eof;
  } tok_t;
endpackage

// File: rtl/r5_stage_ctrl_if.sv
// r5_stage_ctrl_if: sample-stream input and sequencing outputs of one radix-5 stage
interface r5_stage_ctrl_if #(parameter int AW = 5);
  logic          in_valid;
  logic          in_sof;
  logic [2:0]    phase;
  logic [AW-1:0] grp;
  logic [AW-1:0] tw_addr;
  logic          ctl_valid;
  logic          out_valid;
  logic          out_sof;
  logic          out_eof;
  logic          busy;
  logic          err_sync;
  modport master (output in_valid, in_sof,
                  input phase, grp, tw_addr, ctl_valid, out_valid, out_sof, out_eof, busy, err_sync);
  modport slave (input in_valid, in_sof,
                 output phase, grp, tw_addr, ctl_valid, out_valid, out_sof, out_eof, busy, err_sync);
endinterface

// File: rtl/r5_tok_pipe.sv
// r5_tok_pipe: LAT-deep free-running token shift register with occupancy flag
module r5_tok_pipe
  import r5_pkg::*;
#(
  parameter int LAT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  tok_t tok_in,
  output tok_t tok_out,
  output logic any_valid
);
  tok_t [LAT-1:0] pipe_q, pipe_d;
  always_comb begin
    pipe_d = {pipe_q[LAT-2:0], tok_in};
    any_valid = 1'b0;
    for (int i = 0; i < LAT; i++) any_valid |= pipe_q[i].valid;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pipe_q <= '0;
    else pipe_q <= pipe_d;
  assign tok_out = pipe_q[LAT-1];
endmodule

// File: rtl/r5_stage_ctrl.sv
// r5_stage_ctrl: frame sequencer for a radix-5 FFT stage
// phase/grp/tw registers double as the counters: the next sample's values derive from them.
module r5_stage_ctrl
  import r5_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int LAT = LAT_DEF,
  parameter int AW  = AW_DEF
) (
  input logic            clk,
  input logic            rst_n,
  r5_stage_ctrl_if.slave bus
);
  localparam int GRPS = N / RADIX;
  state_t        state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [AW-1:0] grp_q, grp_d, tw_q, tw_d;
  logic          ctl_valid_q, ctl_valid_d, err_q, err_d;
  logic          accept, wrap, last, any_valid;
  logic [AW:0]   tw_sum;
  tok_t          tok_in, tok_out;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    unique case (state_q)
      IDLE:    state_d = bus.in_valid && bus.in_sof ? RUN : IDLE;
      RUN:     state_d = accept && last ? DRAIN : RUN;
      DRAIN:   state_d = bus.in_valid && bus.in_sof ? RUN : any_valid ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    accept = bus.in_valid && (bus.in_sof || state_q == RUN);
    err_d = bus.in_valid && (state_q == RUN ? bus.in_sof : !bus.in_sof);
    ctl_valid_d = accept;
    wrap = phase_q == 3'(RADIX-1);
    phase_d = !accept ? phase_q : (bus.in_sof || wrap) ? 3'd0 : phase_q + 3'd1;
    grp_d = !accept ? grp_q : bus.in_sof ? '0 : wrap ? grp_q + AW'(1) : grp_q;
    // incremental phase*grp mod N: the previous sample in a group shares grp
    tw_sum = {1'b0, tw_q} + {1'b0, grp_d};
    tw_d = !accept ? tw_q : phase_d == '0 ? '0 :
           tw_sum >= (AW+1)'(N) ? AW'(tw_sum - (AW+1)'(N)) : tw_sum[AW-1:0];
    last = phase_d == 3'(RADIX-1) && grp_d == AW'(GRPS-1);
    tok_in = '{valid: accept, sof: accept && bus.in_sof, eof: accept && last};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase_q <= '0;
      grp_q <= '0;
      tw_q <= '0;
      ctl_valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      grp_q <= grp_d;
      tw_q <= tw_d;
      ctl_valid_q <= ctl_valid_d;
      err_q <= err_d;
    end
  r5_tok_pipe #(.LAT(LAT)) u_pipe (
    .clk(clk),
    .rst_n(rst_n),
    .tok_in(tok_in),
    .tok_out(tok_out),
    .any_valid(any_valid)
  );
  assign bus.phase = phase_q;
  assign bus.grp = grp_q;
  assign bus.tw_addr = tw_q;
  assign bus.ctl_valid = ctl_valid_q;
  assign bus.err_sync = err_q;
  assign bus.out_valid = tok_out.valid;
  assign bus.out_sof = tok_out.sof;
  assign bus.out_eof = tok_out.eof;
  // DRAIN with an empty pipe lasts one cycle and already counts as idle
  assign bus.busy = state_q == RUN || any_valid;
endmodule

// File: tb/tb_r5_stage_ctrl.sv
// tb_r5_stage_ctrl: directed scenarios for the radix-5 stage controller
module tb_r5_stage_ctrl;
  import r5_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic sv[256], ss[256];
  logic r_cv[256], r_ov[256], r_os[256], r_oe[256], r_busy[256], r_err[256];
  logic [2:0] r_ph[256];
  logic [4:0] r_gp[256], r_tw[256];
  state_t r_st[256];

  always #5 clk = ~clk;

  r5_stage_ctrl_if #(.AW(5)) bus ();
  r5_stage_ctrl #(.N(25), .LAT(8), .AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic clear_stim();
    for (int k = 0; k < 256; k++) begin
      sv[k] = 1'b0;
      ss[k] = 1'b0;
    end
  endtask

  // record[k] holds outputs during the cycle after the edge that sampled stimulus k
  task automatic drive_rec(input int n);
    for (int k = 0; k < n; k++) begin
      bus.in_valid = sv[k];
      bus.in_sof = ss[k];
      @(posedge clk);
      #1;
      r_cv[k] = bus.ctl_valid; r_ph[k] = bus.phase; r_gp[k] = bus.grp; r_tw[k] = bus.tw_addr;
      r_ov[k] = bus.out_valid; r_os[k] = bus.out_sof; r_oe[k] = bus.out_eof;
      r_busy[k] = bus.busy; r_err[k] = bus.err_sync; r_st[k] = dut.state_q;
    end
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.phase, bus.grp, bus.tw_addr, bus.ctl_valid, bus.out_valid, bus.out_sof, bus.out_eof, bus.busy, bus.err_sync} !== 21'd0 || dut.state_q !== IDLE) begin
      n_bad++;
      $display("FAIL reset_outputs got ph=%0d grp=%0d tw=%0d cv=%b ov=%b busy=%b err=%b st=%0d, expected all 0 / IDLE",
               bus.phase, bus.grp, bus.tw_addr, bus.ctl_valid, bus.out_valid, bus.busy, bus.err_sync, dut.state_q);
    end
    @(negedge clk) rst_n = 1'b1;
    clear_stim();
    drive_rec(2);
    n_cmp++;
    if (r_cv[1] !== 1'b0 || r_ov[1] !== 1'b0 || r_busy[1] !== 1'b0 || r_err[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle got cv=%b ov=%b busy=%b err=%b expected 0", r_cv[1], r_ov[1], r_busy[1], r_err[1]);
    end
  endtask

  task automatic test_single_frame();
    clear_stim();
    for (int k = 0; k < 25; k++) begin
      sv[k] = 1'b1;
      ss[k] = (k == 0);
    end
    drive_rec(40);
    for (int k = 0; k < 25; k++) begin
      n_cmp++;
      if (r_cv[k] !== 1'b1 || r_ph[k] !== 3'(k % 5) || r_gp[k] !== 5'(k / 5) || r_tw[k] !== 5'(((k % 5) * (k / 5)) % 25)) begin
        n_bad++;
        $display("FAIL single_ctl k=%0d got cv=%b ph=%0d grp=%0d tw=%0d expected 1 %0d %0d %0d",
                 k, r_cv[k], r_ph[k], r_gp[k], r_tw[k], k % 5, k / 5, ((k % 5) * (k / 5)) % 25);
      end
    end
    n_cmp++;
    if (r_tw[12] !== 5'd4 || r_tw[14] !== 5'd8) begin
      n_bad++;
      $display("FAIL single_tw_grp2 got %0d %0d expected 4 8", r_tw[12], r_tw[14]);
    end
    n_cmp++;
    if (r_cv[25] !== 1'b0) begin
      n_bad++;
      $display("FAIL single_cv_end got %b expected 0", r_cv[25]);
    end
    for (int k = 0; k < 40; k++) begin
      n_cmp++;
      if (r_ov[k] !== (k >= 7 && k <= 31) || r_os[k] !== (k == 7) || r_oe[k] !== (k == 31) ||
          r_busy[k] !== (k <= 31) || r_err[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL single_tok k=%0d got ov=%b sof=%b eof=%b busy=%b err=%b expected %b %b %b %b 0",
                 k, r_ov[k], r_os[k], r_oe[k], r_busy[k], r_err[k], k >= 7 && k <= 31, k == 7, k == 31, k <= 31);
      end
    end
  endtask

  task automatic test_gaps();
    int eofs;
    clear_stim();
    for (int j = 0; j < 25; j++) begin
      sv[2*j] = 1'b1;
      ss[2*j] = (j == 0);
    end
    drive_rec(60);
    for (int j = 0; j < 25; j++) begin
      n_cmp++;
      if (r_cv[2*j] !== 1'b1 || r_cv[2*j+1] !== 1'b0 || r_ph[2*j] !== 3'(j % 5) || r_ph[2*j+1] !== 3'(j % 5) ||
          r_gp[2*j] !== 5'(j / 5) || r_gp[2*j+1] !== 5'(j / 5)) begin
        n_bad++;
        $display("FAIL gaps_ctl j=%0d got cv=%b/%b ph=%0d/%0d grp=%0d/%0d expected 1/0 %0d %0d",
                 j, r_cv[2*j], r_cv[2*j+1], r_ph[2*j], r_ph[2*j+1], r_gp[2*j], r_gp[2*j+1], j % 5, j / 5);
      end
    end
    eofs = 0;
    for (int k = 0; k < 60; k++) begin
      eofs += int'(r_oe[k]);
      n_cmp++;
      if (r_ov[k] !== (k >= 7 ? sv[k-7] : 1'b0)) begin
        n_bad++;
        $display("FAIL gaps_ov k=%0d got %b expected %b", k, r_ov[k], k >= 7 ? sv[k-7] : 1'b0);
      end
    end
    n_cmp++;
    if (eofs != 1 || r_oe[55] !== 1'b1) begin
      n_bad++;
      $display("FAIL gaps_eof got count=%0d at55=%b expected 1 1", eofs, r_oe[55]);
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    for (int k = 0; k < 50; k++) begin
      sv[k] = 1'b1;
      ss[k] = (k == 0 || k == 25);
    end
    drive_rec(62);
    for (int k = 0; k < 62; k++) begin
      n_cmp++;
      if (r_ov[k] !== (k >= 7 && k <= 56) || r_os[k] !== (k == 7 || k == 32) ||
          r_oe[k] !== (k == 31 || k == 56) || r_err[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_tok k=%0d got ov=%b sof=%b eof=%b err=%b", k, r_ov[k], r_os[k], r_oe[k], r_err[k]);
      end
    end
    n_cmp++;
    if (r_st[23] !== RUN || r_st[24] !== DRAIN || r_st[25] !== RUN) begin
      n_bad++;
      $display("FAIL b2b_state got %0d %0d %0d expected RUN DRAIN RUN", r_st[23], r_st[24], r_st[25]);
    end
    n_cmp++;
    if (r_ph[25] !== 3'd0 || r_gp[25] !== 5'd0 || r_ph[49] !== 3'd4 || r_gp[49] !== 5'd4 || r_tw[49] !== 5'd16) begin
      n_bad++;
      $display("FAIL b2b_ctl got ph=%0d grp=%0d / ph=%0d grp=%0d tw=%0d expected 0 0 / 4 4 16",
               r_ph[25], r_gp[25], r_ph[49], r_gp[49], r_tw[49]);
    end
  endtask

  task automatic test_resync();
    clear_stim();
    for (int k = 0; k < 37; k++) begin
      sv[k] = 1'b1;
      ss[k] = (k == 0 || k == 12);
    end
    drive_rec(49);
    for (int k = 0; k < 49; k++) begin
      n_cmp++;
      if (r_err[k] !== (k == 12) || r_oe[k] !== (k == 43) || r_os[k] !== (k == 7 || k == 19) ||
          r_ov[k] !== (k >= 7 && k <= 43)) begin
        n_bad++;
        $display("FAIL resync_tok k=%0d got err=%b eof=%b sof=%b ov=%b", k, r_err[k], r_oe[k], r_os[k], r_ov[k]);
      end
    end
    n_cmp++;
    if (r_ph[11] !== 3'd1 || r_gp[11] !== 5'd2) begin
      n_bad++;
      $display("FAIL resync_before got ph=%0d grp=%0d expected 1 2", r_ph[11], r_gp[11]);
    end
    for (int k = 12; k < 37; k++) begin
      n_cmp++;
      if (r_ph[k] !== 3'((k - 12) % 5) || r_gp[k] !== 5'((k - 12) / 5)) begin
        n_bad++;
        $display("FAIL resync_ctl k=%0d got ph=%0d grp=%0d expected %0d %0d", k, r_ph[k], r_gp[k], (k - 12) % 5, (k - 12) / 5);
      end
    end
    n_cmp++;
    if (r_busy[43] !== 1'b1 || r_busy[44] !== 1'b0) begin
      n_bad++;
      $display("FAIL resync_busy got %b %b expected 1 0", r_busy[43], r_busy[44]);
    end
  endtask

  task automatic test_drop_and_reset();
    clear_stim();
    for (int k = 0; k < 3; k++) sv[k] = 1'b1;
    for (int k = 4; k < 12; k++) sv[k] = 1'b1;
    ss[4] = 1'b1;
    drive_rec(12);
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (r_err[k] !== (k <= 2) || r_cv[k] !== (k >= 4) || r_busy[k] !== (k >= 4)) begin
        n_bad++;
        $display("FAIL drop k=%0d got err=%b cv=%b busy=%b", k, r_err[k], r_cv[k], r_busy[k]);
      end
    end
    n_cmp++;
    if (r_ph[11] !== 3'd2 || r_gp[11] !== 5'd1) begin
      n_bad++;
      $display("FAIL midframe_ctl got ph=%0d grp=%0d expected 2 1", r_ph[11], r_gp[11]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.phase, bus.grp, bus.tw_addr, bus.ctl_valid, bus.out_valid, bus.out_sof, bus.out_eof, bus.busy, bus.err_sync} !== 21'd0 || dut.state_q !== IDLE) begin
      n_bad++;
      $display("FAIL async_reset got ph=%0d grp=%0d cv=%b ov=%b busy=%b st=%0d expected all 0 / IDLE",
               bus.phase, bus.grp, bus.ctl_valid, bus.out_valid, bus.busy, dut.state_q);
    end
    @(negedge clk) rst_n = 1'b1;
    clear_stim();
    drive_rec(12);
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (r_ov[k] !== 1'b0 || r_os[k] !== 1'b0 || r_oe[k] !== 1'b0 || r_cv[k] !== 1'b0 || r_busy[k] !== 1'b0 ||
          r_err[k] !== 1'b0 || r_ph[k] !== 3'd0 || r_gp[k] !== 5'd0 || r_tw[k] !== 5'd0) begin
        n_bad++;
        $display("FAIL post_reset k=%0d got ov=%b cv=%b busy=%b err=%b ph=%0d grp=%0d expected all 0",
                 k, r_ov[k], r_cv[k], r_busy[k], r_err[k], r_ph[k], r_gp[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gaps();
    test_back_to_back();
    test_resync();
    test_drop_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
